// File: rtl/sdram_bus_arbiter.sv
// Two-master SDRAM command bus arbiter with periodic auto-refresh (whole-transaction grants).
// Define SDRAM_ARB_RR_EN for round-robin M0/M1 arbitration; default is fixed priority M0 > M1.
//
// state      | meaning
// S_IDLE     | bus free, pins NOP; refresh debt beats both masters
// S_GNT0     | M0 owns the bus, its command is registered onto the pins
// S_GNT1     | M1 owns the bus, its command is registered onto the pins
// S_REF_PRE  | PRECHARGE ALL on the pins
// S_REF_WRP  | T_RP NOP cycles
// S_REF_CMD  | REFRESH on the pins
// S_REF_WRFC | T_RFC NOP cycles, then back to idle
module sdram_bus_arbiter #(
  parameter int REF_PERIOD = 780,
  parameter int T_RP       = 3,
  parameter int T_RFC      = 9
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic [3:0]  cmd0,
  input  logic [3:0]  cmd1,
  input  logic [11:0] a0,
  input  logic [11:0] a1,
  input  logic [1:0]  b0,
  input  logic [1:0]  b1,
  input  logic [15:0] d0,
  input  logic [15:0] d1,
  output logic        CSn_SDRAM,
  output logic        RASn_SDRAM,
  output logic        CASn_SDRAM,
  output logic        WEn_SDRAM,
  output logic [11:0] A_SDRAM,
  output logic [1:0]  B_SDRAM,
  output logic [15:0] D_SDRAM,
  output logic        ref_busy,
  output logic        ref_miss
);

  localparam int TMR_W  = $clog2(REF_PERIOD);
  localparam int T_MAX  = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WAIT_W = $clog2(T_MAX + 1);

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT0,
    S_GNT1,
    S_REF_PRE,
    S_REF_WRP,
    S_REF_CMD,
    S_REF_WRFC
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMR_W-1:0]  timer_q;
  logic [1:0]        debt_q;
  logic              miss_q;
  logic              wrap;
  logic              debt_dec;
  logic              pick0, pick1;

  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] a_q, a_d;
  logic [1:0]  b_q, b_d;
  logic [15:0] d_q, d_d;

`ifdef SDRAM_ARB_RR_EN
  // last_q = 1 means M1 owned the bus last, so M0 wins the next contention
  logic last_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && debt_q == 2'd0) begin
      if (pick0)      last_q <= 1'b0;
      else if (pick1) last_q <= 1'b1;
    end
  end

  always_comb begin
    pick0 = req0 && (!req1 || last_q);
    pick1 = req1 && !pick0;
  end
`else
  always_comb begin
    pick0 = req0;
    pick1 = req1 && !req0;
  end
`endif

  assign wrap = (timer_q == TMR_W'(REF_PERIOD - 1));

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      timer_q <= '0;
    end else if (wrap) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Wrap and decrement together cancel; a wrap with the debt already full is a lost refresh
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      debt_q <= 2'd0;
      miss_q <= 1'b0;
    end else if (wrap && !debt_dec) begin
      if (debt_q == 2'd3) miss_q <= 1'b1;
      else                debt_q <= debt_q + 2'd1;
    end else if (debt_dec && !wrap) begin
      debt_q <= debt_q - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cmd_q   <= CMD_NOP;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
    end
  end

  // Pin values are decided with the next state so each state's command appears on entry
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cmd_d    = CMD_NOP;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    debt_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (debt_q != 2'd0) begin
          state_d = S_REF_PRE;
          cmd_d   = CMD_PRE;
          a_d     = 12'h400;
          b_d     = 2'd0;
        end else if (pick0) begin
          state_d = S_GNT0;
        end else if (pick1) begin
          state_d = S_GNT1;
        end
      end
      S_GNT0: begin
        if (req0) begin
          cmd_d = cmd0;
          a_d   = a0;
          b_d   = b0;
          d_d   = d0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GNT1: begin
        if (req1) begin
          cmd_d = cmd1;
          a_d   = a1;
          b_d   = b1;
          d_d   = d1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REF_PRE: begin
        state_d = S_REF_WRP;
        wait_d  = WAIT_W'(T_RP - 1);
      end
      S_REF_WRP: begin
        if (wait_q == '0) begin
          state_d  = S_REF_CMD;
          cmd_d    = CMD_REF;
          debt_dec = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_REF_CMD: begin
        state_d = S_REF_WRFC;
        wait_d  = WAIT_W'(T_RFC - 1);
      end
      S_REF_WRFC: begin
        if (wait_q == '0) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt0     = (state_q == S_GNT0);
  assign gnt1     = (state_q == S_GNT1);
  assign ref_busy = (state_q == S_REF_PRE) || (state_q == S_REF_WRP) ||
                    (state_q == S_REF_CMD) || (state_q == S_REF_WRFC);
  assign ref_miss = miss_q;

  assign {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM} = cmd_q;
  assign A_SDRAM = a_q;
  assign B_SDRAM = b_q;
  assign D_SDRAM = d_q;

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Testbench for sdram_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sdram_bus_arbiter;
  localparam int RP       = 20;
  localparam int TRP      = 3;
  localparam int TRFC     = 9;
  localparam int SEQ_LAST = TRP + TRFC + 1;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        gnt0, gnt1;
  logic [3:0]  cmd0 = 4'hF, cmd1 = 4'hF;
  logic [11:0] a0 = '0, a1 = '0;
  logic [1:0]  b0 = '0, b1 = '0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM;
  logic [11:0] A_SDRAM;
  logic [1:0]  B_SDRAM;
  logic [15:0] D_SDRAM;
  logic        ref_busy, ref_miss;

  int n_checks = 0;
  int n_errors = 0;

  // model: owner 0 = nobody, 1 = M0, 2 = M1, 3 = refresh sequence (m_step = cycle within it)
  int          m_timer = 0, m_debt = 0, m_owner = 0, m_step = 0;
  bit          m_miss = 0, m_last = 1, e_pre = 0;
  logic [3:0]  e_cmd = 4'hF;
  logic [11:0] e_a = '0;
  logic [1:0]  e_b = '0;
  logic [15:0] e_d = '0;

  always #5 CLK = ~CLK;

  sdram_bus_arbiter #(.REF_PERIOD(RP), .T_RP(TRP), .T_RFC(TRFC)) dut (
    .CLK(CLK), .RSTn(RSTn), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .cmd0(cmd0), .cmd1(cmd1), .a0(a0), .a1(a1), .b0(b0), .b1(b1), .d0(d0), .d1(d1),
    .CSn_SDRAM(CSn_SDRAM), .RASn_SDRAM(RASn_SDRAM), .CASn_SDRAM(CASn_SDRAM),
    .WEn_SDRAM(WEn_SDRAM), .A_SDRAM(A_SDRAM), .B_SDRAM(B_SDRAM), .D_SDRAM(D_SDRAM),
    .ref_busy(ref_busy), .ref_miss(ref_miss)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit wrap, dec;
    if (!RSTn) begin
      m_timer = 0; m_debt = 0; m_miss = 0; m_owner = 0; m_step = 0; m_last = 1;
      e_cmd = 4'hF; e_a = '0; e_b = '0; e_d = '0; e_pre = 0;
      return;
    end
    wrap    = (m_timer == RP - 1);
    m_timer = wrap ? 0 : m_timer + 1;
    dec     = (m_owner == 3) && (m_step == TRP);
    e_cmd   = 4'hF;
    case (m_owner)
      0: begin
        if (m_debt > 0) begin
          m_owner = 3; m_step = 0;
          e_cmd = 4'b0010; e_a = 12'h400; e_b = 2'd0; e_pre = 1;
        end else begin
`ifdef SDRAM_ARB_RR_EN
          if (req0 && (!req1 || m_last)) begin m_owner = 1; m_last = 0; end
          else if (req1) begin m_owner = 2; m_last = 1; end
`else
          if (req0) m_owner = 1;
          else if (req1) m_owner = 2;
`endif
        end
      end
      1: begin
        if (req0) begin e_cmd = cmd0; e_a = a0; e_b = b0; e_d = d0; e_pre = 0; end
        else m_owner = 0;
      end
      2: begin
        if (req1) begin e_cmd = cmd1; e_a = a1; e_b = b1; e_d = d1; e_pre = 0; end
        else m_owner = 0;
      end
      default: begin
        if (m_step == SEQ_LAST) m_owner = 0;
        else begin
          m_step++;
          if (m_step == TRP + 1) e_cmd = 4'b0001;
        end
      end
    endcase
    if (wrap && !dec) begin
      if (m_debt == 3) m_miss = 1;
      else m_debt++;
    end else if (dec && !wrap) begin
      m_debt--;
    end
  endtask

  always @(posedge CLK) model_step();

  // Only A[10] is defined for PRECHARGE ALL, so other address bits are ignored after one
  task automatic check_all();
    logic [11:0] a_obs, a_exp;
    a_obs = e_pre ? (A_SDRAM & 12'h400) : A_SDRAM;
    a_exp = e_pre ? 12'h400 : e_a;
    check("pins", {30'd0, CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM, a_obs, B_SDRAM, D_SDRAM},
          {30'd0, e_cmd, a_exp, e_b, e_d});
    check("ctl", {60'd0, gnt0, gnt1, ref_busy, ref_miss},
          {60'd0, m_owner == 1, m_owner == 2, m_owner == 3, m_miss});
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    tick();
    tick();
    RSTn = 1'b1;
  endtask

  task automatic rand_data();
    cmd0 = 4'($urandom); cmd1 = 4'($urandom);
    a0 = 12'($urandom);  a1 = 12'($urandom);
    b0 = 2'($urandom);   b1 = 2'($urandom);
    d0 = 16'($urandom);  d1 = 16'($urandom);
  endtask

  initial begin
    int busy_cnt;
    int len0, len1;

    // reset held with a request pending
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("rst_cmd", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM}, 4'hF);
    check("rst_a", A_SDRAM, 12'h000);
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_miss", ref_miss, 1'b0);

    // M0 alone
    RSTn = 1'b1; cmd0 = 4'b0011; a0 = 12'h155;
    tick();
    check("m0_gnt", gnt0, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    check("m0_pins", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM, A_SDRAM}, {4'b0011, 12'h155});
    req0 = 1'b0;
    tick();
    check("m0_drop_gnt", gnt0, 1'b0);
    check("m0_drop_cmd", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM}, 4'hF);

    // contention
    do_reset();
    rand_data();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("cont_gnt", {gnt0, gnt1}, 2'b10);
    for (int i = 0; i < 4; i++) begin rand_data(); tick(); end
    req0 = 1'b0;
    tick();
    check("cont_idle", {gnt0, gnt1}, 2'b00);
    tick();
    check("cont_gnt1", {gnt0, gnt1}, 2'b01);
    for (int i = 0; i < 3; i++) begin rand_data(); tick(); end
    req1 = 1'b0;
    tick();
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_data(); tick(); end
    req0 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
`ifdef SDRAM_ARB_RR_EN
    check("cont2_gnt", {gnt0, gnt1}, 2'b01);
`else
    check("cont2_gnt", {gnt0, gnt1}, 2'b10);
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // refresh with an idle bus
    do_reset();
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ref_busy) busy_cnt++;
      if (i == 20) check("ref_not_yet", ref_busy, 1'b0);
      if (i == 21) check("ref_pre", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM, A_SDRAM[10], B_SDRAM},
                         {4'b0010, 1'b1, 2'b00});
      if (i == 25) check("ref_cmd", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM}, 4'b0001);
    end
    check("ref_busy_len", busy_cnt, 14);

    // refresh deferred behind a long M1 grant
    do_reset();
    req1 = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 30) req0 = 1'b1;
      rand_data();
      tick();
      if (ref_busy) busy_cnt++;
    end
    check("defer_busy", busy_cnt, 0);
    req1 = 1'b0;
    tick();
    tick();
    check("defer_start", {ref_busy, gnt0}, 2'b10);
    for (int i = 0; i < 40; i++) begin rand_data(); tick(); end
    req0 = 1'b0;
    tick();

    // refresh debt overflow under a 100-cycle M0 grant
    do_reset();
    req0 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      rand_data();
      tick();
      if (i == 79) check("ovf_before", ref_miss, 1'b0);
    end
    check("ovf_miss", ref_miss, 1'b1);
    req0 = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("ovf_sticky", ref_miss, 1'b1);

    // random traffic
    do_reset();
    len0 = 0; len1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        len0 = 0; len1 = 0;
      end
      if (len0 > 0) len0--;
      else if ($urandom_range(0, 3) == 0) len0 = $urandom_range(1, 25);
      if (len1 > 0) len1--;
      else if ($urandom_range(0, 3) == 0) len1 = $urandom_range(1, 25);
      req0 = (len0 > 0);
      req1 = (len1 > 0);
      rand_data();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
